decrypt_pipe: RTL and testbench

Receive-side counterpart of the byte encryption pipeline. It takes ciphertext bytes and recovers plaintext by undoing the two encryption steps in reverse order. First it XORs the byte with the rotating key, then it applies an inverse Caesar shift within the upper-case or lower-case alphabet. It is a 3-stage pipeline with no backpressure. It sits at the far end of the link and uses the same k1/k2/k3, rot_freq, shift and mode configuration as the encrypting end.

---
 rtl/cipher_pkg.sv | 37 +++
 rtl/cipher_key_sched.sv | 49 ++++
 rtl/decrypt_pipe.sv | 95 +++++++++
 tb/tb_decrypt_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared constants, types and helpers for the byte cipher link (both ends).
package cipher_pkg;

  localparam logic [7:0] ASCII_UP_A = 8'h41;
  localparam logic [7:0] ASCII_UP_Z = 8'h5A;
  localparam logic [7:0] ASCII_LO_A = 8'h61;
  localparam logic [7:0] ASCII_LO_Z = 8'h7A;
  localparam logic [5:0] ALPHA_LEN  = 6'd26;

  typedef enum logic [1:0] {KEY1, KEY2, KEY3} key_sel_t;

  // Per-stage payload. offset is the letter position inside its alphabet
  // (0..25) and is only meaningful when upper or lower is set.
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       upper;
    logic       lower;
    logic [4:0] offset;
    logic       shift_en;
    logic [3:0] shift_amt;
  } stage_t;

  // Inverse Caesar step on an alphabet position: (offset - amt) mod 26.
  // amt is at most 15, so a single conditional add of 26 is enough.
  function automatic logic [4:0] unshift(input logic [4:0] offset, input logic [3:0] amt);
    logic [5:0] o;
    logic [5:0] a;
    logic [5:0] r;
    o = {1'b0, offset};
    a = {2'b00, amt};
    if (o >= a) r = o - a;
    else        r = o + ALPHA_LEN - a;
    return r[4:0];
  endfunction

endpackage

// File: rtl/cipher_key_sched.sv
// Rotating key selector shared by the encrypt and decrypt ends. The key in
// use for a byte is the one selected before that byte is counted; the
// selection moves K1 -> K2 -> K3 -> K1 once rot_freq+1 bytes have used it.
module cipher_key_sched
  import cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       acc,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  output logic [7:0] key
);

  key_sel_t   key_sel;
  key_sel_t   sel_next;
  logic [2:0] cnt;

  // Next key index in the rotation and the key currently selected.
  always_comb begin
    sel_next = KEY1;
    key      = k1;
    case (key_sel)
      KEY1:    begin sel_next = KEY2; key = k1; end
      KEY2:    begin sel_next = KEY3; key = k2; end
      KEY3:    begin sel_next = KEY1; key = k3; end
      default: begin sel_next = KEY1; key = k1; end
    endcase
  end

  // Count accepted bytes; >= lets a lowered rot_freq take effect on the
  // very next byte instead of counting up through 7 first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sel <= KEY1;
      cnt     <= 3'd0;
    end else if (acc) begin
      if (cnt >= rot_freq) begin
        cnt     <= 3'd0;
        key_sel <= sel_next;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/decrypt_pipe.sv
// Receive-side byte decryptor: XOR with the rotating key, classify the
// result, then undo the Caesar shift. Valid-only streaming: a byte is taken
// on every clk edge where en=1, there is no ready/stall, and v pulses for
// exactly one cycle per byte, three edges after the accepting edge.
module decrypt_pipe
  import cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  input  logic       shift_en,
  input  logic [3:0] shift_amt,
  input  logic       mode,
  output logic       v,
  output logic [7:0] dout
);

  logic [7:0] key;
  stage_t     s1;
  stage_t     s2;
  stage_t     s3;
  logic       up_c;
  logic       lo_c;

  cipher_key_sched u_key_sched (
    .clk      (clk),
    .rst      (rst),
    .acc      (en),
    .k1       (k1),
    .k2       (k2),
    .k3       (k3),
    .rot_freq (rot_freq),
    .key      (key)
  );

  assign up_c = (s1.data >= ASCII_UP_A) && (s1.data <= ASCII_UP_Z);
  assign lo_c = (s1.data >= ASCII_LO_A) && (s1.data <= ASCII_LO_Z);

  // Stage 1: accept the byte, strip the key (unless bypassed), latch shift config.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
    end else begin
      s1           <= '0;
      s1.valid     <= en;
      s1.data      <= mode ? din : (din ^ key);
      s1.shift_en  <= shift_en;
      s1.shift_amt <= shift_amt;
    end
  end

  // Stage 2: classify into upper/lower alphabet and take the alphabet offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2 <= '0;
    end else begin
      s2       <= s1;
      s2.upper <= up_c;
      s2.lower <= lo_c;
      if (up_c)      s2.offset <= 5'(s1.data - ASCII_UP_A);
      else if (lo_c) s2.offset <= 5'(s1.data - ASCII_LO_A);
      else           s2.offset <= 5'd0;
    end
  end

  // Stage 3: apply the inverse shift to letters when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3 <= '0;
    end else begin
      s3 <= s2;
      if (s2.shift_en && (s2.upper || s2.lower))
        s3.offset <= unshift(s2.offset, s2.shift_amt);
    end
  end

  // Output register: rebuild the letter from its base, pass others through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v    <= 1'b0;
      dout <= 8'h00;
    end else begin
      v <= s3.valid;
      if (s3.upper)      dout <= ASCII_UP_A + {3'b000, s3.offset};
      else if (s3.lower) dout <= ASCII_LO_A + {3'b000, s3.offset};
      else               dout <= s3.data;
    end
  end

endmodule

// File: tb/tb_decrypt_pipe.sv
// Directed and randomized round-trip bench for decrypt_pipe.
module tb_decrypt_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] k1, k2, k3;
  logic [2:0] rot_freq;
  logic       shift_en;
  logic [3:0] shift_amt;
  logic       mode;
  logic       v;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0] exp_q[$];
  int         due_q[$];

  // reference key schedule for the round-trip phase
  int         m_sel;
  int         m_cnt;

  decrypt_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .k1        (k1),
    .k2        (k2),
    .k3        (k3),
    .rot_freq  (rot_freq),
    .shift_en  (shift_en),
    .shift_amt (shift_amt),
    .mode      (mode),
    .v         (v),
    .dout      (dout)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge against the expected queue.
  task automatic tick();
    @(posedge clk);
    cycle++;
    #1;
    if (due_q.size() > 0 && due_q[0] == cycle) begin
      chk("v_pulse", {7'b0, v}, 8'h01);
      chk("dout", dout, exp_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk("v_idle", {7'b0, v}, 8'h00);
    end
  endtask

  // Present one byte for a single edge; its result is due 3 edges later.
  task automatic send(input logic [7:0] d, input logic [7:0] exp);
    en  = 1'b1;
    din = d;
    exp_q.push_back(exp);
    due_q.push_back(cycle + 4);
    tick();
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    idle(6);
    chk("drain_empty", 8'(due_q.size()), 8'h00);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_v", {7'b0, v}, 8'h00);
    chk("rst_dout", dout, 8'h00);
    exp_q.delete();
    due_q.delete();
    en = 1'b0;
    idle(2);
    rst   = 1'b1;
    m_sel = 0;
    m_cnt = 0;
  endtask

  function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] key,
                                     input logic m, input logic se, input logic [3:0] amt);
    logic [7:0] s;
    int off;
    s = p;
    if (se && p >= 8'h41 && p <= 8'h5A) begin
      off = int'(p) - 'h41;
      s = 8'('h41 + (off + int'(amt)) % 26);
    end else if (se && p >= 8'h61 && p <= 8'h7A) begin
      off = int'(p) - 'h61;
      s = 8'('h61 + (off + int'(amt)) % 26);
    end
    return m ? s : (s ^ key);
  endfunction

  initial begin
    logic [7:0] p;
    logic [7:0] c;
    logic [7:0] key;

    rst = 1'b0; en = 1'b0; din = 8'h00;
    k1 = 8'h00; k2 = 8'h00; k3 = 8'h00; rot_freq = 3'd7;
    shift_en = 1'b0; shift_amt = 4'd0; mode = 1'b0;
    m_sel = 0; m_cnt = 0;

    // power-on reset state
    tick();
    chk("por_v", {7'b0, v}, 8'h00);
    chk("por_dout", dout, 8'h00);
    rst = 1'b1;
    idle(1);

    // upper-case, lower-case wrap and zero shift, all under K1
    k1 = 8'h20; k2 = 8'hAA; k3 = 8'h55; rot_freq = 3'd7;
    mode = 1'b0; shift_en = 1'b1; shift_amt = 4'd3;
    send(8'h64, 8'h41);
    send(8'h42, 8'h79);
    shift_amt = 4'd0;
    send(8'h7A, 8'h5A);
    drain();

    // non-alpha passes through unshifted
    do_reset();
    k1 = 8'h0F; shift_en = 1'b1; shift_amt = 4'd9;
    send(8'h3A, 8'h35);
    drain();

    // reset mid-stream: bytes in flight, one output visible right now
    k1 = 8'h00; shift_en = 1'b0;
    send(8'h11, 8'h11);
    send(8'h12, 8'h12);
    send(8'h13, 8'h13);
    send(8'h14, 8'h14);
    do_reset();
    idle(4);

    // key rotation, back to back, rot_freq=1; first byte after reset uses K1
    k1 = 8'h01; k2 = 8'h02; k3 = 8'h03; rot_freq = 3'd1;
    shift_en = 1'b0; mode = 1'b0;
    send(8'h31, 8'h30); send(8'h31, 8'h30);
    send(8'h32, 8'h30); send(8'h32, 8'h30);
    send(8'h33, 8'h30); send(8'h33, 8'h30);
    send(8'h31, 8'h30);
    drain();

    // same with a 2-cycle en gap: schedule must hold during the gap
    do_reset();
    send(8'h31, 8'h30); send(8'h31, 8'h30); send(8'h32, 8'h30);
    din = 8'hFF;
    idle(2);
    send(8'h32, 8'h30); send(8'h33, 8'h30); send(8'h33, 8'h30);
    send(8'h31, 8'h30);
    drain();

    // lowering rot_freq mid-count advances after the very next byte
    do_reset();
    rot_freq = 3'd7;
    send(8'h31, 8'h30); send(8'h31, 8'h30); send(8'h31, 8'h30); send(8'h31, 8'h30);
    rot_freq = 3'd1;
    send(8'h31, 8'h30);
    send(8'h32, 8'h30);
    drain();

    // XOR bypass, shift-only
    do_reset();
    mode = 1'b1; shift_en = 1'b1; shift_amt = 4'd3; k1 = 8'h5C;
    send(8'h44, 8'h41);
    drain();

    // random round trip through a reference encryptor
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      k1 = 8'($urandom_range(0, 255));
      k2 = 8'($urandom_range(0, 255));
      k3 = 8'($urandom_range(0, 255));
      rot_freq  = 3'($urandom_range(0, 7));
      mode      = 1'($urandom_range(0, 1));
      shift_en  = 1'($urandom_range(0, 1));
      shift_amt = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       p = 8'($urandom_range('h41, 'h5A));
        1:       p = 8'($urandom_range('h61, 'h7A));
        default: p = 8'($urandom_range(0, 255));
      endcase
      key = (m_sel == 0) ? k1 : (m_sel == 1) ? k2 : k3;
      c = enc(p, key, mode, shift_en, shift_amt);
      send(c, p);
      if (m_cnt >= int'(rot_freq)) begin
        m_cnt = 0;
        m_sel = (m_sel + 1) % 3;
      end else begin
        m_cnt++;
      end
      if ($urandom_range(0, 7) == 0) begin
        din = 8'($urandom_range(0, 255));
        tick();
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
